// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register bank's single write port: ALU results vs buffered
// load returns, with a per-register pending-load scoreboard driving the decode stall.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int LDQ_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_hold,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  output logic            stall,
  output logic            regWrite,
  output logic [4:0]      writePort,
  output logic [XLEN-1:0] wBus
);

  localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [4:0]      ldq_rd_q   [LDQ_DEPTH];
  logic [XLEN-1:0] ldq_data_q [LDQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     cnt_q, cnt_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic [31:0]     pending_q, pending_d;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      wport_q, wport_d;
  logic [XLEN-1:0] wbus_q, wbus_d;

  logic fifo_empty, fifo_full, starve, alu_win, ld_win, push;
  logic [4:0]      head_rd, win_rd;
  logic [XLEN-1:0] head_data, win_data;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(LDQ_DEPTH));
  assign starve     = (starve_q == CW'(STARVE_MAX));
  assign head_rd    = ldq_rd_q[rd_ptr_q];
  assign head_data  = ldq_data_q[rd_ptr_q];

  // A starved load only preempts the ALU when there is actually something buffered.
  assign alu_win  = alu_valid && !(starve && !fifo_empty);
  assign ld_win   = !alu_win && !fifo_empty;
  assign win_rd   = alu_win ? alu_rd : head_rd;
  assign win_data = alu_win ? alu_data : head_data;

  assign ld_ready = rst_n && !fifo_full;
  assign push     = ld_valid && ld_ready;
  assign alu_hold = rst_n && alu_valid && !alu_win;
  assign stall    = rst_n && (pending_q[dec_rs1] | pending_q[dec_rs2] | pending_q[dec_rd]);

  assign regWrite  = regwrite_q;
  assign writePort = wport_q;
  assign wBus      = wbus_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    pending_d  = pending_q;
    regwrite_d = 1'b0;
    wport_d    = wport_q;
    wbus_d     = wbus_q;

    case ({push, ld_win})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if (fifo_empty || ld_win)   starve_d = '0;
    else if (alu_win && !starve) starve_d = starve_q + CW'(1);

    if ((alu_win || ld_win) && (win_rd != 5'd0)) begin
      regwrite_d = 1'b1;
      wport_d    = win_rd;
      wbus_d     = win_data;
    end

    // Clear before set so a same-rd re-issue in the commit cycle stays pending.
    if (ld_win && (head_rd != 5'd0)) pending_d[head_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0)) pending_d[ld_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      pending_q  <= '0;
      regwrite_q <= 1'b0;
      wport_q    <= '0;
      wbus_q     <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (ld_win) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      regwrite_q <= regwrite_d;
      wport_q    <= wport_d;
      wbus_q     <= wbus_d;
    end
  end

  // NOTE: buffer storage is not reset; the count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ldq_rd_q[wr_ptr_q]   <= ld_rd;
      ldq_data_q[wr_ptr_q] <= ld_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes expected bank writes,
// a negedge monitor pops and compares each regWrite.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, ld_issue;
  logic [4:0]  alu_rd, ld_rd, ld_issue_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] alu_data, ld_data;
  logic        alu_hold, ld_ready, stall, regWrite;
  logic [4:0]  writePort;
  logic [31:0] wBus;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  regfile_wb_arbiter #(.XLEN(32), .LDQ_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_hold(alu_hold),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .stall(stall),
    .regWrite(regWrite), .writePort(writePort), .wBus(wBus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs, check combinational outputs at negedge, advance past posedge.
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                     input logic e_hold, input logic e_ready, input logic e_stall,
                     input int e_rw);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldd;
    @(negedge clk);
    check("alu_hold", 64'(alu_hold), 64'(e_hold));
    check("ld_ready", 64'(ld_ready), 64'(e_ready));
    check("stall",    64'(stall),    64'(e_stall));
    if (e_rw >= 0) check("regWrite", 64'(regWrite), 64'(e_rw));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (regWrite === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_commit: got port %0d data %0h, expected no write (t=%0t)",
                 writePort, wBus, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_port", 64'(writePort), 64'(e.rd));
        check("commit_data", 64'(wBus),      64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ld_issue = 1'b0; ld_issue_rd = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_regWrite",  64'(regWrite),  64'(0));
    check("rst_writePort", 64'(writePort), 64'(0));
    check("rst_wBus",      64'(wBus),      64'(0));
    check("rst_alu_hold",  64'(alu_hold),  64'(0));
    check("rst_ld_ready",  64'(ld_ready),  64'(0));
    check("rst_stall",     64'(stall),     64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU only
    sb_push(5'd5, 32'hDEADBEEF);
    cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 1, 0, 0);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 0, 1, 0, 1);

    // Load only: pending set by issue, cleared with the bank write
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 0, 0);
    ld_issue = 1'b0; dec_rs1 = 5'd7;
    sb_push(5'd7, 32'h12345678);
    cyc(0, 5'd0, 32'h0, 1, 5'd7, 32'h12345678, 0, 1, 1, 0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,        0, 1, 1, 0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,        0, 1, 0, 1);
    dec_rs1 = 5'd0;

    // Contention and starvation with one buffered load to rd=3
    sb_push(5'd10, 32'hA0);
    cyc(1, 5'd10, 32'hA0, 1, 5'd3, 32'h33, 0, 1, 0, -1);
    for (int i = 0; i < 4; i++) begin
      sb_push(5'(11 + i), 32'hB0 + 32'(i));
      cyc(1, 5'(11 + i), 32'hB0 + 32'(i), 0, 5'd0, 32'h0, 0, 1, 0, -1);
    end
    sb_push(5'd3, 32'h33);
    cyc(1, 5'd15, 32'hC5, 0, 5'd0, 32'h0, 1, 1, 0, -1);
    sb_push(5'd15, 32'hC5);
    cyc(1, 5'd15, 32'hC5, 0, 5'd0, 32'h0, 0, 1, 0, 1);

    // Backpressure: three loads back-to-back under continuous ALU traffic
    sb_push(5'd16, 32'h100); cyc(1, 5'd16, 32'h100, 1, 5'd20, 32'h200, 0, 1, 0, -1);
    sb_push(5'd17, 32'h101); cyc(1, 5'd17, 32'h101, 1, 5'd21, 32'h201, 0, 1, 0, -1);
    sb_push(5'd18, 32'h102); cyc(1, 5'd18, 32'h102, 1, 5'd22, 32'h202, 0, 0, 0, -1);
    sb_push(5'd19, 32'h103); cyc(1, 5'd19, 32'h103, 1, 5'd22, 32'h202, 0, 0, 0, -1);
    sb_push(5'd23, 32'h104); cyc(1, 5'd23, 32'h104, 1, 5'd22, 32'h202, 0, 0, 0, -1);
    sb_push(5'd20, 32'h200); cyc(1, 5'd24, 32'h105, 1, 5'd22, 32'h202, 1, 0, 0, -1);
    sb_push(5'd24, 32'h105); cyc(1, 5'd24, 32'h105, 1, 5'd22, 32'h202, 0, 1, 0, -1);
    sb_push(5'd21, 32'h201); cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, -1);
    sb_push(5'd22, 32'h202); cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 0, -1);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 0, 1);

    // rd=0 ALU result is consumed but never written
    cyc(1, 5'd0, 32'h55, 0, 5'd0, 32'h0, 0, 1, 0, 0);
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 0, 0);

    // Same-rd set and clear: re-issue to rd=9 in the commit cycle keeps it pending
    ld_issue = 1'b0; dec_rd = 5'd9;
    sb_push(5'd9, 32'h99);
    cyc(0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 1, 1, 0);
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 1, 0);
    ld_issue = 1'b0;
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 1, 1);
    dec_rd = 5'd0;

    // Reset mid-operation: two buffered loads, pending bits 2 and 7 (plus 9)
    ld_issue = 1'b1; ld_issue_rd = 5'd2;
    sb_push(5'd25, 32'h250);
    cyc(1, 5'd25, 32'h250, 1, 5'd2, 32'h2, 0, 1, 0, 0);
    ld_issue_rd = 5'd7;
    sb_push(5'd26, 32'h260);
    cyc(1, 5'd26, 32'h260, 1, 5'd7, 32'h7, 0, 1, 0, 1);
    ld_issue = 1'b0; rst_n = 1'b0;
    dec_rs1 = 5'd2; dec_rs2 = 5'd7; dec_rd = 5'd9;
    cyc(1, 5'd27, 32'h270, 0, 5'd0, 32'h0, 0, 0, 0, 1);
    rst_n = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    check("post_rst_regWrite",  64'(regWrite),  64'(0));
    check("post_rst_writePort", 64'(writePort), 64'(0));
    check("post_rst_wBus",      64'(wBus),      64'(0));
    check("post_rst_stall",     64'(stall),     64'(0));
    check("post_rst_ld_ready",  64'(ld_ready),  64'(1));
    @(posedge clk);
    #1;
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 0, 0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 0, 0);

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
